sobel_window_builder: RTL
=========================

# sobel_window_builder

- Streaming producer of the 3x3 pixel window consumed by the horizontal and vertical gradient blocks.
- Accepts one 8-bit grayscale pixel per valid cycle in raster order and keeps two line buffers plus a 3x3 shift window.
- Drives `windowBuffer[0:8]` and pulses `start_calculations` once for every fully populated interior window.
- Sits between the pixel input interface and the gradient/magnitude datapath.

## Interface
Parameters:
- `IMG_WIDTH`, 640: pixels per row, ≥3.
- `IMG_HEIGHT`, 480: rows per frame, ≥3.

Ports:
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `frame_start`  in  1  one-cycle pulse; begins a new frame.
- `pixel_valid`  in  1  `pixel_in` is valid this cycle.
- `pixel_in`  in  8  grayscale pixel, raster order.
- `ready`  out  1  high while a frame is in progress (state ACTIVE).
- `windowBuffer`  out  8 x [0:8]  window, row-major: [0..2] top row, [3..5] middle row, [6..8] bottom row; [0] is the oldest pixel, [8] is the newest.
- `start_calculations`  out  1  one-cycle pulse; `windowBuffer` holds a new complete window.
- `frame_done`  out  1  one-cycle pulse after the last pixel of the frame is accepted.

## Operation
- Accept condition: `accept = pixel_valid && (state==ACTIVE || frame_start)`.
- Pixels outside ACTIVE are ignored unless `frame_start` is high in the same cycle.
- FSM:
  - IDLE → ACTIVE on `frame_start`.
  - ACTIVE → DONE on the accept at (row H-1, col W-1).
  - DONE → IDLE unconditionally. `frame_done`=1 only in DONE.
  - `frame_start` in any state → ACTIVE with `row`=`col`=0. If that pixel is accepted in the same cycle, it is pixel (0,0).
- Counters:
  - `col` runs 0..W-1; at W-1 it wraps to 0 and `row` increments.
  - `row` runs 0..H-1.
- Line buffers `lb1`, `lb2`: W entries x 8 bits each, indexed by `col`. On accept at column c:
  - top = `lb2[c]`, mid = `lb1[c]`, bot = `pixel_in`.
  - `lb2[c]` ← `lb1[c]`; `lb1[c]` ← `pixel_in`.
- Window shift on accept (the new column enters on the right):
  - `w0`←`w1`, `w1`←`w2`, `w2`←top.
  - `w3`←`w4`, `w4`←`w5`, `w5`←mid.
  - `w6`←`w7`, `w7`←`w8`, `w8`←bot.
- Window registers drive `windowBuffer` directly. They hold their value when there is no accept.
- `start_calculations` ← `accept && row≥2 && col≥2`, using the pre-increment counters.
  - Windows at col 0/1 contain stale pixels from the previous row's right edge; they are never flagged.
  - Each frame produces exactly (W-2)(H-2) pulses.
- No border padding. Edge pixels produce no window.
- Window pixels are unsigned 8-bit. No arithmetic is performed on them.

## Timing
- Reset values:
  - `windowBuffer` all 0.
  - `start_calculations`, `frame_done`, `ready` = 0.
  - state IDLE; `row`, `col` = 0.
  - Line buffer contents need not be reset.
- Latency: window and `start_calculations` are registered and visible in the cycle after the accepting edge.
- `start_calculations` is high for exactly one cycle per qualifying accept.
- Back-to-back accepts give back-to-back pulses.
- There is no backpressure; gaps in `pixel_valid` simply stall the counters.
- `frame_done` is high in the cycle after the final accept. It coincides with the final `start_calculations` pulse.
- `frame_start` mid-frame:
  - Counters restart and no pulse is issued until row 2, col 2 of the new frame.
  - Stale line-buffer data is never flagged.
- `n_rst` asserted mid-frame: all outputs return to reset values immediately (asynchronous), and any pending pulse is dropped.
- `frame_start` coinciding with the final accept: the restart wins, and no DONE/`frame_done` occurs.

## Configuration
- `SOBEL_COORD_OUT_EN` defined:
  - Adds output ports `out_row[15:0]` and `out_col[15:0]`, both reset to 0.
  - They carry the window-centre coordinates (row-1, col-1) of the accept.
  - Registered alongside `windowBuffer`, updated only when `start_calculations` is set.
- `SOBEL_COORD_OUT_EN` undefined: the ports and their registers are absent. All other behaviour is identical.

## Test plan
Bench uses W=H=4 and `pixel_in` = 10·row+col.
- Reset → all outputs 0, `ready`=0. `pixel_valid`=1 without `frame_start` → no change.
- Full frame with continuous valid → exactly 4 pulses, one cycle each, after accepts (2,2),(2,3),(3,2),(3,3).
  - First window = {0,1,2,10,11,12,20,21,22}; gy = 80 when fed to the gradient block.
  - `frame_done` coincides with the 4th pulse.
- Same frame with `pixel_valid` toggled 1-0-1 → identical windows and pulse count; `windowBuffer` holds during the gaps.
- `frame_start` at row 2 col 1 with a new frame of all-255 → no pulse until new (2,2); that window = nine 255s; 4 pulses total.
- `n_rst` low at row 3 col 0 → outputs 0 immediately. A later `frame_start` with a full frame → normal 4 pulses.
- With `SOBEL_COORD_OUT_EN`: the pulses carry `out_row`/`out_col` = (1,1),(1,2),(2,1),(2,2).

Source files
------------

// File: rtl/sobel_window_builder.sv
// Streams raster-order pixels through two line buffers and a 3x3 shift window,
// flagging each complete interior window. Optional macro: SOBEL_COORD_OUT_EN.
module sobel_window_builder #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       frame_start,
  input  logic       pixel_valid,
  input  logic [7:0] pixel_in,
  output logic       ready,
  output logic [7:0] windowBuffer [0:8],
  output logic       start_calculations,
`ifdef SOBEL_COORD_OUT_EN
  output logic [15:0] out_row,
  output logic [15:0] out_col,
`endif
  output logic       frame_done
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_col;
  logic [CW-1:0]   w_col_cur;
  logic [CW-1:0]   w_col_nxt;
  logic [RW-1:0]   r_row;
  logic [RW-1:0]   w_row_cur;
  logic [RW-1:0]   w_row_nxt;
  logic            w_accept;
  logic            w_last;
  logic            w_qualify;
  logic [7:0]      w_top;
  logic [7:0]      w_mid;
  logic [7:0]      r_lb1 [IMG_WIDTH];
  logic [7:0]      r_lb2 [IMG_WIDTH];
  logic [7:0]      r_win [0:8];

  // A frame_start pulse rebases the counters so its own pixel lands at (0,0).
  assign w_accept  = pixel_valid && ((r_state == S_ACTIVE) || frame_start);
  assign w_col_cur = frame_start ? '0 : r_col;
  assign w_row_cur = frame_start ? '0 : r_row;
  assign w_last    = (w_row_cur == RW'(IMG_HEIGHT - 1)) && (w_col_cur == CW'(IMG_WIDTH - 1));
  assign w_qualify = w_accept && (w_row_cur >= RW'(2)) && (w_col_cur >= CW'(2));
  assign w_top     = r_lb2[w_col_cur];
  assign w_mid     = r_lb1[w_col_cur];

  // Next-state and counter advance.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = w_row_cur;
    w_col_nxt   = w_col_cur;
    if (frame_start) begin
      w_state_nxt = S_ACTIVE;
    end else begin
      case (r_state)
        S_IDLE:   w_state_nxt = S_IDLE;
        S_ACTIVE: if (w_accept && w_last) w_state_nxt = S_DONE;
        S_DONE:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
    if (w_accept) begin
      if (w_col_cur == CW'(IMG_WIDTH - 1)) begin
        w_col_nxt = '0;
        w_row_nxt = (w_row_cur == RW'(IMG_HEIGHT - 1)) ? '0 : w_row_cur + RW'(1);
      end else begin
        w_col_nxt = w_col_cur + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state            <= S_IDLE;
      r_row              <= '0;
      r_col              <= '0;
      ready              <= 1'b0;
      frame_done         <= 1'b0;
      start_calculations <= 1'b0;
    end else begin
      r_state            <= w_state_nxt;
      r_row              <= w_row_nxt;
      r_col              <= w_col_nxt;
      ready              <= (w_state_nxt == S_ACTIVE);
      frame_done         <= (w_state_nxt == S_DONE);
      start_calculations <= w_qualify;
    end
  end

  // Line buffers carry the two previous rows; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb2[w_col_cur] <= r_lb1[w_col_cur];
      r_lb1[w_col_cur] <= pixel_in;
    end
  end

  // New column enters on the right of each window row.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
    end else if (w_accept) begin
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= w_top;
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= w_mid;
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= pixel_in;
    end
  end

  assign windowBuffer = r_win;

`ifdef SOBEL_COORD_OUT_EN
  // Window-centre coordinates, captured only with a flagged window.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_row <= '0;
      out_col <= '0;
    end else if (w_qualify) begin
      out_row <= 16'(w_row_cur) - 16'd1;
      out_col <= 16'(w_col_cur) - 16'd1;
    end
  end
`endif

endmodule
